// File: rtl/hex_display.sv
// hex_display: assembles keypad-style hex digits (MSB-first shift) into a
// 32-bit value and drives a time-multiplexed 7-segment digit scan.
// Optional build macro: HEX_DISPLAY_SKIP_BLANK_EN -- when defined, the scan
// only visits positions that hold entered digits (at least position 0).
module hex_display #(
  parameter int SCAN_DIV = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  hex,
  input  logic        pulse,
  input  logic        clear,
  output logic [31:0] value,
  output logic [3:0]  digits,
  output logic        full,
  output logic [3:0]  seg_data,
  output logic [2:0]  seg_an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [31:0]   value_reg,   value_next;
  logic [3:0]    digits_reg,  digits_next;
  logic [CW-1:0] div_cnt_reg, div_cnt_next;
  logic [2:0]    seg_an_reg,  seg_an_next;
  logic          scan_wrap;
  logic [2:0]    scan_next_idx;
  logic [3:0]    nibble [8];

  // Split the value into per-position nibbles for the display mux.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
      assign nibble[gi] = value_reg[4*gi +: 4];
    end
  endgenerate

  assign scan_wrap = (div_cnt_reg == CW'(SCAN_DIV - 1));

`ifdef HEX_DISPLAY_SKIP_BLANK_EN
  logic [3:0] scan_limit;
  logic [3:0] seg_an_inc;

  // Advance within lit digits only; with no digits entered, stay on 0.
  always_comb begin
    scan_limit    = (digits_reg == 4'd0) ? 4'd1 : digits_reg;
    seg_an_inc    = {1'b0, seg_an_reg} + 4'd1;
    scan_next_idx = (seg_an_inc >= scan_limit) ? 3'd0 : seg_an_inc[2:0];
  end
`else
  // Advance through all eight positions, wrapping naturally at 8.
  always_comb begin
    scan_next_idx = seg_an_reg + 3'd1;
  end
`endif

  // Next-state for entry register, digit count and scan divider.
  always_comb begin
    value_next   = value_reg;
    digits_next  = digits_reg;
    div_cnt_next = scan_wrap ? '0 : div_cnt_reg + 1'b1;
    seg_an_next  = scan_wrap ? scan_next_idx : seg_an_reg;
    if (clear) begin
      // Clear wins over a same-cycle pulse and restarts the scan too.
      value_next   = '0;
      digits_next  = '0;
      div_cnt_next = '0;
      seg_an_next  = '0;
    end else if (pulse) begin
      value_next = {value_reg[27:0], hex};
      if (digits_reg != 4'd8) begin
        digits_next = digits_reg + 4'd1;
      end
    end
  end

  // State registers with synchronous reset overriding all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg   <= '0;
      digits_reg  <= '0;
      div_cnt_reg <= '0;
      seg_an_reg  <= '0;
    end else begin
      value_reg   <= value_next;
      digits_reg  <= digits_next;
      div_cnt_reg <= div_cnt_next;
      seg_an_reg  <= seg_an_next;
    end
  end

  assign value    = value_reg;
  assign digits   = digits_reg;
  assign full     = (digits_reg == 4'd8);
  assign seg_an   = seg_an_reg;
  assign seg_data = nibble[seg_an_reg];

endmodule

// File: tb/tb_hex_display.sv
// Scoreboard bench for hex_display (SCAN_DIV=4). Stimulus pushes expected
// values; a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_hex_display;

  localparam int DIV = 4;
`ifdef HEX_DISPLAY_SKIP_BLANK_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  hex = 4'd0;
  logic        pulse = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] value;
  logic [3:0]  digits;
  logic        full;
  logic [3:0]  seg_data;
  logic [2:0]  seg_an;

  hex_display #(.SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .hex(hex), .pulse(pulse), .clear(clear),
    .value(value), .digits(digits), .full(full),
    .seg_data(seg_data), .seg_an(seg_an)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;   // 0 value, 1 digits, 2 full, 3 seg_an, 4 seg_data
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n = 0;            // edges since last rst/clear
  logic [31:0] cur_val;   // expected entered value (hand-set per test)

  // Monitor: compare every queued expectation on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        0: act = value;
        1: act = {28'd0, digits};
        2: act = {31'd0, full};
        3: act = {29'd0, seg_an};
        default: act = {28'd0, seg_data};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", e.name, act, e.exp, $time);
      end else begin
        $display("ok   %s = 0x%0h (t=%0t)", e.name, act, $time);
      end
    end
  end

  task automatic push(input string nm, input int sel, input logic [31:0] ex);
    exp_t e;
    e.name = nm; e.sel = sel; e.exp = ex;
    sb.push_back(e);
  endtask

  task automatic step(input logic p, input logic [3:0] h, input logic c, input logic r);
    pulse = p; hex = h; clear = c; rst = r;
    @(posedge clk); #1;
    if (r || c) n = 0; else n++;
    pulse = 1'b0; clear = 1'b0; rst = 1'b0;
  endtask

  task automatic push_entry(input string tag, input logic [31:0] v, input int d);
    push({tag, ".value"}, 0, v);
    push({tag, ".digits"}, 1, d);
    push({tag, ".full"}, 2, (d == 8) ? 32'd1 : 32'd0);
  endtask

  // Expected scan position: index = (n/DIV) mod lim for the tests used here.
  task automatic push_scan(input string tag, input int lim);
    int an;
    an = (n / DIV) % lim;
    push({tag, ".seg_an"}, 3, an);
    push({tag, ".seg_data"}, 4, (cur_val >> (4 * an)) & 32'hF);
  endtask

  initial begin
    // Reset held two cycles with a pulse present.
    step(1'b1, 4'h5, 1'b0, 1'b1);
    step(1'b1, 4'h5, 1'b0, 1'b1);
    cur_val = 32'h0;
    push_entry("reset", 32'h0, 0);
    push("reset.seg_an", 3, 0);
    push("reset.seg_data", 4, 0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    // Entry of 1,2,3 with idle cycles between pulses.
    step(1'b1, 4'h1, 1'b0, 1'b0); push("entry1.value", 0, 32'h1);
    step(1'b0, 4'h0, 1'b0, 1'b0); push("entry1_idle.value", 0, 32'h1);
    step(1'b1, 4'h2, 1'b0, 1'b0); push("entry2.value", 0, 32'h12);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'h3, 1'b0, 1'b0); push_entry("entry3", 32'h123, 3);

    // Overflow: 1..9 after a clear.
    step(1'b0, 4'h0, 1'b1, 1'b0); push_entry("clr", 32'h0, 0);
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 4'(i), 1'b0, 1'b0);
      if (i == 8) push_entry("ovf8", 32'h12345678, 8);
    end
    push_entry("ovf9", 32'h23456789, 8);

    // Collision of clear and pulse.
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b0); push("coll_pre.value", 0, 32'h12);
    step(1'b1, 4'hA, 1'b1, 1'b0); push_entry("coll", 32'h0, 0);
    step(1'b1, 4'h4, 1'b0, 1'b0); push_entry("coll_next", 32'h4, 1);

    // Full scan of 0x87654321 (pulse held for 8 cycles).
    step(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 8; i >= 1; i--) step(1'b1, 4'(i), 1'b0, 1'b0);
    cur_val = 32'h87654321;
    push_entry("scan_val", cur_val, 8);
    for (int k = 0; k < 36; k++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      push_scan("scan", 8);
    end

    // Two digits A,B: skip build alternates positions 0/1.
    step(1'b0, 4'h0, 1'b1, 1'b0);
    step(1'b1, 4'hA, 1'b0, 1'b0);
    step(1'b1, 4'hB, 1'b0, 1'b0);
    cur_val = 32'hAB;
    push_entry("ab", cur_val, 2);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      push_scan("ab", SKIP ? 2 : 8);
    end

    // After clear: no digits, skip build stays at 0.
    step(1'b0, 4'h0, 1'b1, 1'b0);
    cur_val = 32'h0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      push_scan("empty", SKIP ? 1 : 8);
    end

    // Reset mid-entry/mid-scan restarts everything.
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    push_entry("rst_mid", 32'h0, 0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'h0, 1'b0, 1'b0);
      push_scan("rst_mid", SKIP ? 1 : 8);
    end

    @(posedge clk); @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
